// File: rtl/cpu_mem_pkg.sv
// Shared constants and encodings for the unified instruction/data memory.
// Defines address/data widths, the .text/.data split, and arbiter FSM/owner codes.
package cpu_mem_pkg;

    localparam int ADDR_W     = 12;
    localparam int DATA_W     = 32;
    localparam int TEXT_WORDS = 2048;
    localparam int DATA_BASE  = 2048;
    localparam int MAX_WAIT   = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_SPI = 1'b1
    } owner_e;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating count of SPI arbitration losses; clear has priority over inc.
// Ports: clk, reset (async active-low), inc, clr -> cnt (0..MAX_WAIT).
module arb_wait_counter #(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = $clog2(MAX_WAIT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CNT_W'(MAX_WAIT))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified memory between CPU (req 0) and SPI (req 1): CPU priority, SPI starvation guard.
// Ports: cpu_*/spi_* req/ack pairs, mem_* memory strobe/data, busy, prot_err; macro MEM_ARB_TEXT_PROTECT_EN.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W     = cpu_mem_pkg::ADDR_W,
    parameter int DATA_W     = cpu_mem_pkg::DATA_W,
    parameter int MAX_WAIT   = cpu_mem_pkg::MAX_WAIT,
    parameter int TEXT_WORDS = cpu_mem_pkg::TEXT_WORDS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              spi_req,
    input  logic              spi_we,
    input  logic [ADDR_W-1:0] spi_addr,
    input  logic [DATA_W-1:0] spi_wdata,
    output logic              spi_ack,
    output logic [DATA_W-1:0] spi_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              prot_err
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              we_q, we_d;
    logic              blk_q, blk_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic             idle;
    logic             resp;
    logic             sat;
    logic             cpu_win;
    logic             spi_win;
    logic             text_wr;
    logic [CNT_W-1:0] wait_cnt;

    assign idle = (state_q == ST_IDLE);
    assign resp = (state_q == ST_RESP);
    assign sat  = (wait_cnt == CNT_W'(MAX_WAIT));

    // SPI takes the slot once it has lost MAX_WAIT decisions in a row.
    assign cpu_win = cpu_req && !(spi_req && sat);
    assign spi_win = spi_req && !cpu_win;

`ifdef MEM_ARB_TEXT_PROTECT_EN
    assign text_wr  = cpu_we &&
        ({1'b0, cpu_addr} < (ADDR_W + 1)'(TEXT_WORDS));
    assign prot_err = resp && blk_q;
`else
    assign text_wr  = 1'b0;
    assign prot_err = 1'b0;
`endif

    arb_wait_counter #(
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CNT_W)
    ) u_wait (
        .clk   (clk),
        .reset (reset),
        .inc   (idle && cpu_win && spi_req),
        .clr   (idle && spi_win),
        .cnt   (wait_cnt)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        blk_d   = blk_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cpu_win) begin
                    state_d = ST_ACCESS;
                    owner_d = OWN_CPU;
                    we_d    = cpu_we;
                    blk_d   = text_wr;
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                end else if (spi_win) begin
                    state_d = ST_ACCESS;
                    owner_d = OWN_SPI;
                    we_d    = spi_we;
                    blk_d   = 1'b0;
                    addr_d  = spi_addr;
                    wdata_d = spi_wdata;
                end
            end
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_CPU;
            we_q    <= 1'b0;
            blk_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            blk_q   <= blk_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Outputs decode straight from state so an async reset clears them at once.
    assign busy      = !idle;
    assign mem_en    = (state_q == ST_ACCESS);
    assign mem_we    = mem_en && we_q && !blk_q;
    assign mem_addr  = mem_en ? addr_q : '0;
    assign mem_wdata = mem_en ? wdata_q : '0;

    assign cpu_ack   = resp && (owner_q == OWN_CPU);
    assign spi_ack   = resp && (owner_q == OWN_SPI);
    assign cpu_rdata = (cpu_ack && !we_q) ? mem_rdata : '0;
    assign spi_rdata = (spi_ack && !we_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random traffic
// checked every cycle against a transaction-level schedule model.
module tb_mem_port_arbiter;

    localparam int AW = cpu_mem_pkg::ADDR_W;
    localparam int DW = cpu_mem_pkg::DATA_W;
    localparam int MW = cpu_mem_pkg::MAX_WAIT;
    localparam int TW = cpu_mem_pkg::TEXT_WORDS;
`ifdef MEM_ARB_TEXT_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          cpu_req = 0, cpu_we = 0, spi_req = 0, spi_we = 0;
    logic [AW-1:0] cpu_addr = '0, spi_addr = '0;
    logic [DW-1:0] cpu_wdata = '0, spi_wdata = '0;
    logic          cpu_ack, spi_ack, mem_en, mem_we, busy, prot_err;
    logic [DW-1:0] cpu_rdata, spi_rdata, mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [AW-1:0] mem_addr;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .reset(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .spi_req(spi_req), .spi_we(spi_we), .spi_addr(spi_addr),
        .spi_wdata(spi_wdata), .spi_ack(spi_ack), .spi_rdata(spi_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .prot_err(prot_err)
    );

    // Memory array driven by the DUT (synchronous read).
    logic [DW-1:0] ram [0:4095];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    function automatic logic [31:0] seed_word(input int a);
        return (32'(a) * 32'h0001_0101) ^ 32'h5A00_0000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: each grant owns the port for three edges;
    // the grant edge opens the access cycle, the next one the response cycle.
    logic [DW-1:0] mdl_mem [0:4095];
    int            edge_n = 0, free_at = 0, losses = 0, tx_g = 0;
    bit            tx_v = 0, tx_spi = 0, tx_we = 0, tx_blk = 0, spi_wins = 0;
    logic [AW-1:0] tx_addr = '0;
    logic [DW-1:0] tx_wdata = '0, tx_rdata = '0;
    bit            e_en = 0, e_we = 0, e_cack = 0, e_sack = 0;
    bit            e_busy = 0, e_prot = 0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_wdata = '0, e_crd = '0, e_srd = '0;

    always @(posedge clk or negedge rst_n) begin
        e_en = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_cack = 0;
        e_sack = 0; e_crd = '0; e_srd = '0; e_busy = 0; e_prot = 0;
        if (!rst_n) begin
            tx_v = 0; losses = 0; free_at = 0; edge_n = 0;
        end else begin
            edge_n = edge_n + 1;
            if (edge_n >= free_at && (cpu_req || spi_req)) begin
                spi_wins = spi_req && (!cpu_req || losses == MW);
                if (spi_wins) losses = 0;
                else if (spi_req && losses < MW) losses = losses + 1;
                tx_v = 1; tx_g = edge_n; tx_spi = spi_wins;
                tx_we    = spi_wins ? spi_we : cpu_we;
                tx_addr  = spi_wins ? spi_addr : cpu_addr;
                tx_wdata = spi_wins ? spi_wdata : cpu_wdata;
                tx_blk = PROT && !spi_wins && tx_we && (int'(tx_addr) < TW);
                tx_rdata = '0;
                if (tx_we) begin
                    if (!tx_blk) mdl_mem[tx_addr] = tx_wdata;
                end else begin
                    tx_rdata = mdl_mem[tx_addr];
                end
                free_at = edge_n + 3;
            end
            if (tx_v && edge_n == tx_g) begin
                e_en = 1; e_we = tx_we && !tx_blk; e_addr = tx_addr;
                e_wdata = tx_wdata; e_busy = 1;
            end
            if (tx_v && edge_n == tx_g + 1) begin
                e_cack = !tx_spi; e_sack = tx_spi; e_busy = 1;
                e_prot = tx_blk;
                if (tx_spi) e_srd = tx_rdata; else e_crd = tx_rdata;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("mem_en", mem_en, e_en);
            chk("mem_we", mem_we, e_we);
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_wdata", mem_wdata, e_wdata);
            chk("cpu_ack", cpu_ack, e_cack);
            chk("spi_ack", spi_ack, e_sack);
            chk("cpu_rdata", cpu_rdata, e_crd);
            chk("spi_rdata", spi_rdata, e_srd);
            chk("busy", busy, e_busy);
            chk("prot_err", prot_err, e_prot);
        end
    end

    // Issue one request and hold it until ack (or drop it after the grant).
    task automatic do_txn(input string nm, input bit who, input bit we,
                          input int addr, input logic [31:0] wd,
                          input bit drop, output logic [31:0] rd,
                          output bit pe, output int lat, output bit en1,
                          output bit oth);
        bit ack;
        rd = '0; pe = 0; lat = 0; en1 = 0; oth = 0;
        if (who) begin
            spi_req = 1; spi_we = we; spi_addr = AW'(addr); spi_wdata = wd;
        end else begin
            cpu_req = 1; cpu_we = we; cpu_addr = AW'(addr); cpu_wdata = wd;
        end
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) en1 = mem_en;
            ack = who ? spi_ack : cpu_ack;
            oth = oth | (who ? cpu_ack : spi_ack);
            if (ack) begin
                lat = k; pe = prot_err;
                rd = who ? spi_rdata : cpu_rdata;
                break;
            end
            if (drop && k == 1) begin
                #1;
                if (who) spi_req = 0; else cpu_req = 0;
            end
        end
        if (lat == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_timeout: got no ack want ack within 10", nm);
        end
        #1;
        if (who) spi_req = 0; else cpu_req = 0;
        @(negedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        return AW'(($urandom_range(0, 1) ? 2048 : 0) + $urandom_range(0, 7));
    endfunction

    logic [31:0] rd;
    bit          pe, en1, oth, cpend, spend;
    int          lat;
    string       seq;

    initial begin
        for (int a = 0; a < 4096; a++) begin
            ram[a] = seed_word(a);
            mdl_mem[a] = seed_word(a);
        end
        ram[2048] = 32'hDEADBEEF;
        mdl_mem[2048] = 32'hDEADBEEF;
        #1 rst_n = 0;
        chk_on = 1;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_cpu_ack", cpu_ack, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        #1 rst_n = 1;
        @(negedge clk); #1;

        do_txn("t1", 0, 0, 2048, 0, 0, rd, pe, lat, en1, oth);
        chk("t1_en", en1, 1);
        chk("t1_lat", lat, 2);
        chk("t1_rdata", rd, 32'hDEADBEEF);
        chk("t1_spi_ack", oth, 0);

        do_txn("t2w", 1, 1, 2050, 32'h12345678, 0, rd, pe, lat, en1, oth);
        chk("t2_wlat", lat, 2);
        do_txn("t2r", 0, 0, 2050, 0, 0, rd, pe, lat, en1, oth);
        chk("t2_rdata", rd, 32'h12345678);

        do_txn("t5c", 0, 1, 5, 32'hFFFFFFFF, 0, rd, pe, lat, en1, oth);
        chk("t5_cack_lat", lat, 2);
        chk("t5_prot", pe, PROT);
        do_txn("t5r", 1, 0, 5, 0, 0, rd, pe, lat, en1, oth);
        chk("t5_mem5", rd, PROT ? seed_word(5) : 32'hFFFFFFFF);
        do_txn("t5s", 1, 1, 5, 32'hA5A5A5A5, 0, rd, pe, lat, en1, oth);
        chk("t5_spi_prot", pe, 0);
        do_txn("t5v", 0, 0, 5, 0, 0, rd, pe, lat, en1, oth);
        chk("t5_spi_wr", rd, 32'hA5A5A5A5);

        do_txn("t6", 0, 0, 2051, 0, 1, rd, pe, lat, en1, oth);
        chk("t6_lat", lat, 2);
        chk("t6_rdata", rd, seed_word(2051));
        chk("t6_busy", busy, 0);
        chk("t6_ack_once", cpu_ack, 0);

        cpu_req = 1; cpu_we = 0; cpu_addr = AW'(2048);
        @(posedge clk); #2;
        chk("t4_en_pre", mem_en, 1);
        rst_n = 0;
        #1;
        chk("t4_en", mem_en, 0);
        chk("t4_we", mem_we, 0);
        chk("t4_busy", busy, 0);
        cpu_req = 0;
        repeat (2) begin
            @(negedge clk);
            chk("t4_noack", cpu_ack, 0);
        end
        #1 rst_n = 1;
        @(negedge clk); #1;
        do_txn("t4", 0, 0, 2048, 0, 0, rd, pe, lat, en1, oth);
        chk("t4_lat", lat, 2);
        chk("t4_rdata", rd, 32'hDEADBEEF);

        seq = "";
        cpu_req = 1; cpu_we = 0; cpu_addr = AW'(2049);
        spi_req = 1; spi_we = 0; spi_addr = AW'(2052);
        for (int k = 0; k < 60 && seq.len() < 15; k++) begin
            @(negedge clk);
            if (cpu_ack) seq = {seq, "C"};
            if (spi_ack) seq = {seq, "S"};
        end
        #1 cpu_req = 0; spi_req = 0;
        n_cmp++;
        if (seq != "CCCCSCCCCSCCCCS") begin
            n_bad++;
            $display("FAIL t3_pattern: got %s want CCCCSCCCCSCCCCS", seq);
        end
        repeat (3) @(negedge clk);
        #1;

        cpend = 0; spend = 0;
        repeat (3000) begin
            @(negedge clk);
            #1;
            if (cpend && cpu_ack) begin
                cpend = 0; cpu_req = 0;
            end else if (cpend && cpu_req && tx_v && !tx_spi &&
                         edge_n == tx_g && $urandom_range(0, 3) == 0) begin
                cpu_req = 0;
            end else if (!cpend && $urandom_range(0, 2) == 0) begin
                cpend = 1; cpu_req = 1; cpu_we = 1'($urandom_range(0, 1));
                cpu_addr = rand_addr(); cpu_wdata = $urandom;
            end
            if (spend && spi_ack) begin
                spend = 0; spi_req = 0;
            end else if (spend && spi_req && tx_v && tx_spi &&
                         edge_n == tx_g && $urandom_range(0, 3) == 0) begin
                spi_req = 0;
            end else if (!spend && $urandom_range(0, 2) == 0) begin
                spend = 1; spi_req = 1; spi_we = 1'($urandom_range(0, 1));
                spi_addr = rand_addr(); spi_wdata = $urandom;
            end
        end
        cpu_req = 0; spi_req = 0;
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
